// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Issues in-order word-aligned requests to
// instruction memory, buffers returned words in a QDEPTH-entry queue so that
// decode stalls never backpressure memory, and owns the decode-stage
// pipeline register (InstrD / PCD / PCPlus4D / ValidD). A redirect from
// execute (PCSrcE) reloads the fetch PC, flushes the queue and the decode
// register, and marks every in-flight response as stale.
//
// Configuration macro:
//   FETCH_BYPASS_EN - when defined, a live response is written straight into
//                     the decode register if the queue is empty and decode
//                     is loading (response-to-InstrD latency N+1 instead of
//                     N+2). Issue, redirect and discard rules are unchanged.
//
// Ports:
//   clk, rst          core clock (rising edge), async active-high reset
//   imem_req_valid    fetch request valid (combinational issue rule)
//   imem_req_ready    memory accepts the request
//   imem_addr         fetch address (registered fetch PC)
//   imem_rsp_valid    in-order response valid, no backpressure
//   imem_rsp_data     returned instruction word
//   StallD            hold decode register
//   PCSrcE, PCTargetE redirect request and target
//   InstrD, PCD,      decode-stage instruction, its PC and PC+4
//   PCPlus4D
//   ValidD            InstrD holds a real instruction (else bubble)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    QDEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  StallD,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(32'd4);

    // Fetch PC, bookkeeping counters
    logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [CW-1:0]         out_q, out_d;       // accepted, not yet answered
    logic [CW-1:0]         disc_q, disc_d;     // responses still to drop

    // Instruction queue (storage + pointers)
    logic [DATA_WIDTH-1:0] q_instr_q [QDEPTH];
    logic [DATA_WIDTH-1:0] q_pc_q    [QDEPTH];
    logic [PW-1:0]         q_head_q, q_head_d;
    logic [PW-1:0]         q_tail_q, q_tail_d;
    logic [CW-1:0]         q_count_q, q_count_d;

    // Addresses of in-flight requests, in issue order
    logic [DATA_WIDTH-1:0] ifl_pc_q [QDEPTH];
    logic [PW-1:0]         ifl_wr_q, ifl_wr_d;
    logic [PW-1:0]         ifl_rd_q, ifl_rd_d;

    // Decode-stage register
    logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
    logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
    logic [DATA_WIDTH-1:0] pc_p4_d_q, pc_p4_d_d;
    logic                  valid_d_q, valid_d_d;

    logic [CW:0]           occ_s;
    logic                  req_fire_s;
    logic                  rsp_keep_s;
    logic                  dec_load_s;
    logic                  q_empty_s;
    logic                  bypass_s;
    logic                  q_pop_s;
    logic                  q_push_s;
    logic [DATA_WIDTH-1:0] rsp_pc_s;

    // Issue rule: requests in flight plus buffered words never exceed the
    // queue depth, so every response is guaranteed a slot.
    assign occ_s          = {1'b0, out_q} + {1'b0, q_count_q};
    assign imem_req_valid = !rst && !PCSrcE && (occ_s < (CW+1)'(QDEPTH));
    assign imem_addr      = pc_f_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;

    assign rsp_pc_s   = ifl_pc_q[ifl_rd_q];
    assign rsp_keep_s = imem_rsp_valid && (disc_q == {CW{1'b0}}) && !PCSrcE;
    assign dec_load_s = !StallD || !valid_d_q;
    assign q_empty_s  = (q_count_q == {CW{1'b0}});

`ifdef FETCH_BYPASS_EN
    assign bypass_s = rsp_keep_s && dec_load_s && q_empty_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign q_pop_s  = !PCSrcE && dec_load_s && !q_empty_s;
    assign q_push_s = rsp_keep_s && !bypass_s;

    assign InstrD   = instr_d_q;
    assign PCD      = pc_d_q;
    assign PCPlus4D = pc_p4_d_q;
    assign ValidD   = valid_d_q;

    // Next-state computation for PC, counters, queue pointers and decode register
    always_comb begin
        pc_f_d    = pc_f_q;
        out_d     = out_q;
        disc_d    = disc_q;
        q_head_d  = q_head_q;
        q_tail_d  = q_tail_q;
        q_count_d = q_count_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pc_p4_d_d = pc_p4_d_q;
        valid_d_d = valid_d_q;

        // Every response retires one in-flight address, stale or not.
        ifl_rd_d = imem_rsp_valid ? (ifl_rd_q + PW'(1'b1)) : ifl_rd_q;
        ifl_wr_d = req_fire_s     ? (ifl_wr_q + PW'(1'b1)) : ifl_wr_q;

        if (PCSrcE) begin
            pc_f_d    = PCTargetE;
            q_head_d  = {PW{1'b0}};
            q_tail_d  = {PW{1'b0}};
            q_count_d = {CW{1'b0}};
            // No request issues this cycle, so only a response changes out.
            out_d     = out_q - CW'(imem_rsp_valid);
            disc_d    = out_q - CW'(imem_rsp_valid);
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
        end else begin
            if (req_fire_s) begin
                pc_f_d = pc_f_q + WORD_STEP;
            end else begin
                pc_f_d = pc_f_q;
            end
            out_d = out_q + CW'(req_fire_s) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (disc_q != {CW{1'b0}})) begin
                disc_d = disc_q - CW'(1'b1);
            end else begin
                disc_d = disc_q;
            end

            q_head_d  = q_pop_s  ? (q_head_q + PW'(1'b1)) : q_head_q;
            q_tail_d  = q_push_s ? (q_tail_q + PW'(1'b1)) : q_tail_q;
            q_count_d = q_count_q + CW'(q_push_s) - CW'(q_pop_s);

            if (dec_load_s) begin
                if (q_pop_s) begin
                    instr_d_d = q_instr_q[q_head_q];
                    pc_d_d    = q_pc_q[q_head_q];
                    pc_p4_d_d = q_pc_q[q_head_q] + WORD_STEP;
                    valid_d_d = 1'b1;
                end else if (bypass_s) begin
                    instr_d_d = imem_rsp_data;
                    pc_d_d    = rsp_pc_s;
                    pc_p4_d_d = rsp_pc_s + WORD_STEP;
                    valid_d_d = 1'b1;
                end else begin
                    // Bubble keeps PCD/PCPlus4D of the previous instruction.
                    instr_d_d = NOP_INSTR;
                    valid_d_d = 1'b0;
                end
            end else begin
                valid_d_d = valid_d_q;
            end
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q    <= RESET_PC;
            out_q     <= {CW{1'b0}};
            disc_q    <= {CW{1'b0}};
            q_head_q  <= {PW{1'b0}};
            q_tail_q  <= {PW{1'b0}};
            q_count_q <= {CW{1'b0}};
            ifl_wr_q  <= {PW{1'b0}};
            ifl_rd_q  <= {PW{1'b0}};
            instr_d_q <= NOP_INSTR;
            pc_d_q    <= {DATA_WIDTH{1'b0}};
            pc_p4_d_q <= WORD_STEP;
            valid_d_q <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            q_head_q  <= q_head_d;
            q_tail_q  <= q_tail_d;
            q_count_q <= q_count_d;
            ifl_wr_q  <= ifl_wr_d;
            ifl_rd_q  <= ifl_rd_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            pc_p4_d_q <= pc_p4_d_d;
            valid_d_q <= valid_d_d;
        end
    end

    // Queue and in-flight address storage; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (q_push_s) begin
            q_instr_q[q_tail_q] <= imem_rsp_data;
            q_pc_q[q_tail_q]    <= rsp_pc_s;
        end
        if (req_fire_s) begin
            ifl_pc_q[ifl_wr_q] <= pc_f_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          DW  = 32;
    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          StallD;
    logic          PCSrcE;
    logic [DW-1:0] PCTargetE;
    logic [DW-1:0] InstrD;
    logic [DW-1:0] PCD;
    logic [DW-1:0] PCPlus4D;
    logic          ValidD;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mem_lat     = 1;

    // Memory: pending accepted requests with the cycle they answer in
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];

    // Model: fetch stream as program-order addresses, buffered words, decode slot
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ient_t;
    ient_t       m_q[$];
    logic [31:0] m_pc, m_rsp_pc, m_instrD, m_pcD;
    logic        m_validD;
    int          m_out, m_disc;
    logic        m_reqv;
    logic        acc_l;
    logic [31:0] acc_addr_l;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = RPC;
        m_rsp_pc = RPC;
        m_instrD = NOP;
        m_pcD    = 32'h0;
        m_validD = 1'b0;
        m_out    = 0;
        m_disc   = 0;
    endtask

    // One clock edge of the fetch stage, described as program-order fetching
    task automatic model_step();
        logic  acc, kept, load;
        ient_t e, h;
        acc = m_reqv && imem_req_ready;
        if (PCSrcE) begin
            m_pc     = PCTargetE;
            m_rsp_pc = PCTargetE;
            m_q.delete();
            m_instrD = NOP;
            m_validD = 1'b0;
            if (imem_rsp_valid) m_out--;
            m_disc   = m_out;
        end else begin
            kept = imem_rsp_valid && (m_disc == 0);
            if (imem_rsp_valid && m_disc > 0) m_disc--;
            e = '{m_rsp_pc, mem_word(m_rsp_pc)};
            if (kept) m_rsp_pc += 32'd4;
            load = !StallD || !m_validD;
            if (load) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    m_instrD = h.instr; m_pcD = h.pc; m_validD = 1'b1;
                end
`ifdef FETCH_BYPASS_EN
                else if (kept) begin
                    m_instrD = e.instr; m_pcD = e.pc; m_validD = 1'b1;
                    kept = 1'b0;
                end
`endif
                else begin
                    m_instrD = NOP; m_validD = 1'b0;
                end
            end
            if (kept) m_q.push_back(e);
            if (acc) begin m_pc += 32'd4; m_out++; end
            if (imem_rsp_valid) m_out--;
        end
    endtask

    // Drive one cycle's inputs, then compare DUT against model mid-cycle
    task automatic cyc_begin(input logic r, input logic stall, input logic pcsrc,
                             input logic [31:0] tgt, input logic ready);
        rst = r; StallD = stall; PCSrcE = pcsrc; PCTargetE = tgt; imem_req_ready = ready;
        if (r) begin model_reset(); mem_q.delete(); end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!r && mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        m_reqv = !r && !pcsrc && ((m_out + m_q.size()) < QD);
        @(negedge clk);
        chk("req_valid", {31'h0, imem_req_valid}, {31'h0, m_reqv});
        if (m_reqv) chk("imem_addr", imem_addr, m_pc);
        chk("ValidD", {31'h0, ValidD}, {31'h0, m_validD});
        chk("InstrD", InstrD, m_instrD);
        chk("PCD", PCD, m_pcD);
        chk("PCPlus4D", PCPlus4D, m_pcD + 32'd4);
        acc_l      = imem_req_valid && imem_req_ready;
        acc_addr_l = imem_addr;
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (!rst) begin
            if (acc_l) mem_q.push_back('{acc_addr_l, cyc + mem_lat});
            model_step();
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int lat);
        mem_lat = lat;
        cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); cyc_end();
        cyc_begin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); cyc_end();
    endtask

    initial begin
        // Reset release, 1-cycle memory, free-running decode
        do_reset(1);
        for (int k = 0; k < 12; k++) begin
            cyc_begin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                chk("t1_first_valid", {31'h0, imem_req_valid}, 32'd1);
                chk("t1_first_addr", imem_addr, 32'h0);
            end
            if (k == 3 - BYP) begin
                chk("t1_word0", InstrD, 32'hECA8_0000);
                chk("t1_pc0", PCD, 32'h0);
                chk("t1_valid0", {31'h0, ValidD}, 32'd1);
            end
            if (k == 4 - BYP) chk("t1_pc1", PCD, 32'h4);
            cyc_end();
        end

        // Decode stalled for 10 cycles: queue fills and issue stops
        for (int k = 0; k < 10; k++) begin
            cyc_begin(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            if (k == 9) chk("t2_issue_stopped", {31'h0, imem_req_valid}, 32'd0);
            cyc_end();
        end
        for (int k = 0; k < 12; k++) begin
            cyc_begin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); cyc_end();
        end

        // 3-cycle memory, redirect with 3 requests outstanding
        do_reset(3);
        for (int k = 0; k < 12; k++) begin
            cyc_begin(1'b0, 1'b0, (k == 3), 32'h100, 1'b1);
            if (k == 4) begin
                chk("t3_req_valid", {31'h0, imem_req_valid}, 32'd1);
                chk("t3_addr", imem_addr, 32'h100);
            end
            if (k >= 5 && k <= 8 - BYP) chk("t3_bubble", {31'h0, ValidD}, 32'd0);
            if (k == 9 - BYP) begin
                chk("t3_target_instr", InstrD, mem_word(32'h100));
                chk("t3_target_pc", PCD, 32'h100);
            end
            cyc_end();
        end

        // Back-to-back redirects: only the second stream survives
        do_reset(3);
        for (int k = 0; k < 14; k++) begin
            cyc_begin(1'b0, 1'b0, (k == 3 || k == 4), (k == 3) ? 32'h100 : 32'h200, 1'b1);
            if (k == 5) chk("t4_addr", imem_addr, 32'h200);
            if (k == 10 - BYP) begin
                chk("t4_target_pc", PCD, 32'h200);
                chk("t4_target_valid", {31'h0, ValidD}, 32'd1);
            end
            cyc_end();
        end

        // Memory not ready for 5 cycles: address holds at 0x8
        do_reset(1);
        for (int k = 0; k < 16; k++) begin
            cyc_begin(1'b0, 1'b0, 1'b0, 32'h0, !(k >= 2 && k <= 6));
            if (k >= 2 && k <= 6) chk("t5_addr_hold", imem_addr, 32'h8);
            cyc_end();
        end

        // Reset pulsed mid-stream while words are buffered
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            cyc_begin(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); cyc_end();
        end
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_instr", InstrD, NOP);
        chk("t6_pcd", PCD, 32'h0);
        chk("t6_pcp4", PCPlus4D, 32'h4);
        chk("t6_valid", {31'h0, ValidD}, 32'd0);
        chk("t6_req", {31'h0, imem_req_valid}, 32'd0);
        cyc_end();
        for (int k = 0; k < 10; k++) begin
            cyc_begin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) chk("t6_restart_addr", imem_addr, RPC);
            if (k == 3 - BYP) chk("t6_restart_instr", InstrD, mem_word(RPC));
            cyc_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined core. It sits directly upstream of the decode-stage control unit and produces the `InstrD`/`PCD`/`PCPlus4D` triple that decode consumes. It issues in-order requests to instruction memory, buffers returned words in a small queue so that decode stalls do not stall memory, and owns the decode-stage pipeline register. On a taken branch or jump from execute it redirects the PC, flushes the queue and the decode register, and discards stale in-flight responses.

## Interface
- `DATA_WIDTH`, 32, instruction/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `QDEPTH`, 4, queue entries (power of two, ≥2); also the outstanding-request bound

- `clk` in 1: core clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request
- `imem_addr` out DATA_WIDTH: fetch address (word aligned)
- `imem_rsp_valid` in 1: response valid; in order, ≥1 cycle after acceptance, no backpressure
- `imem_rsp_data` in DATA_WIDTH: returned instruction
- `StallD` in 1: hold decode register (from hazard unit)
- `PCSrcE` in 1: redirect (taken branch/jump in execute)
- `PCTargetE` in DATA_WIDTH: redirect target
- `InstrD` out DATA_WIDTH: decode-stage instruction, registered
- `PCD` out DATA_WIDTH: PC of `InstrD`
- `PCPlus4D` out DATA_WIDTH: `PCD + 4`
- `ValidD` out 1: `InstrD` holds a real instruction (else bubble)

## Operation
- Fetch PC register `pcF`; a request is accepted when `imem_req_valid && imem_req_ready`, then `pcF += 4` (mod 2^DATA_WIDTH, wraps silently).
- `imem_req_valid = !PCSrcE && (outstanding + count) < QDEPTH`; `imem_addr = pcF`. This guarantees every response has a queue slot.
- `outstanding` is +1 on accept and −1 on response; both together leave it unchanged.
- A PC queue of depth QDEPTH parallels requests in flight, so the address of each response is known.
- Response handling:
  - If `discard > 0`: the response is dropped and `discard` decrements.
  - Otherwise the {instr, pc} pair is pushed to the queue.
- Decode register loads when `!StallD || !ValidD`:
  - queue non-empty: pop the head and set `ValidD=1`;
  - queue empty: load bubble (`InstrD=32'h0000_0013`, `ValidD=0`, `PCD` unchanged).
- Redirect (`PCSrcE=1`) takes priority over everything:
  - `pcF <= PCTargetE`;
  - queue cleared;
  - decode register set to bubble;
  - `discard <= outstanding − imem_rsp_valid`, so every in-flight request, including the one answering this cycle, is dropped;
  - no request is issued this cycle.
- A redirect during an active discard recomputes `discard` by the same rule, so all in-flight requests are stale.
- `StallD` with a full queue: requests stop via the issue rule, and memory is never backpressured.

## Timing
- Reset values: `pcF=RESET_PC`; queue empty; `outstanding=0`; `discard=0`; `imem_req_valid=0` while `rst`; `InstrD=32'h0000_0013`; `PCD=0`; `PCPlus4D=4`; `ValidD=0`.
- First request is issued in the first cycle after `rst` deasserts.
- Latency from response (cycle N) to `InstrD`: N+2 (queue write at edge N, decode load at edge N+1).
- Redirect asserted in cycle R:
  - `imem_addr=PCTargetE` with valid in R+1;
  - first target instruction appears in `InstrD` no earlier than `accept + mem latency + 2`.
- `rst` mid-operation: all state returns to reset values at once. In-flight memory responses after reset are not tracked; memory must reset on the same `rst`.
- Queue full with `StallD` held: `count` stays at `QDEPTH` and no words are lost.
- Full pop and push in the same cycle are both allowed.

## Configuration
- `FETCH_BYPASS_EN` defined: a non-discarded response is written directly into the decode register when the queue is empty and the decode register is loading. Latency drops to N+1, and the bypassed word is not pushed to the queue.
- Not defined: all responses go through the queue, with latency N+2.
- Issue rule, redirect and discard behaviour are identical in both builds.

## Test plan
- Reset release, memory with 1-cycle latency, `StallD=0`:
  - addresses 0, 4, 8, 12… are requested;
  - `InstrD` shows word@0 at cycle 3 (cycle 2 with bypass), then one instruction per cycle with `PCD` matching.
- `StallD=1` for 10 cycles with a steady stream:
  - queue reaches 4 and `imem_req_valid` drops;
  - after release, `InstrD` sequence continues with no gap, duplicate or loss.
- Memory with 3-cycle latency, 3 outstanding, `PCSrcE=1` with `PCTargetE=0x100`:
  - the 3 stale responses are dropped;
  - `ValidD=0` until word@0x100 arrives;
  - the next request is 0x100.
- Back-to-back redirects (0x100 then 0x200 next cycle) with requests in flight: only the 0x200 stream reaches `InstrD`.
- `imem_req_ready=0` for 5 cycles: `imem_addr` holds 0x8, and `outstanding` does not increase.
- `rst` pulsed mid-stream with the queue holding 3 entries: outputs return to reset values immediately, and fetch restarts at `RESET_PC`.
